// File: rtl/melody_arbiter.sv
// Melody arbiter: grants one of NUM_CH melody players at a time and routes its PWM to the buzzer.
// Defining MELODY_PREEMPT_EN lets a winning pending request abort the melody that is playing.
module melody_arbiter #(
    parameter int NUM_CH          = 4,
    parameter int ARB_MODE        = 0,
    parameter int GAP_CYCLES      = 100_000,
    parameter int MAX_PLAY_CYCLES = 0,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn,
    input  logic [NUM_CH-1:0] done,
    input  logic [NUM_CH-1:0] melody,
    output logic [NUM_CH-1:0] en,
    output logic              buzz,
    output logic              busy,
    output logic [CH_W-1:0]   active_ch,
    output logic [NUM_CH-1:0] pending,
    output logic              timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WD_W  = (MAX_PLAY_CYCLES > 1) ? $clog2(MAX_PLAY_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [CH_W-1:0]   act_q, act_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] btn_prev_q;
    logic              buzz_q, buzz_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] grant_oh_s;
    logic [NUM_CH-1:0] block_s;
    logic [CH_W-1:0]   sel_s;
    logic              wd_hit_s;
    logic              preempt_s;

    function automatic logic [CH_W-1:0] pick_fixed(input logic [NUM_CH-1:0] req);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            r = req[i] ? CH_W'(i) : r;
        end
        return r;
    endfunction

    // Scan downwards so the request closest after 'last' is the final assignment.
    function automatic logic [CH_W-1:0] pick_rr(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   last);
        logic [CH_W-1:0] r;
        int              idx;
        r = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_CH;
            r   = req[idx] ? CH_W'(idx) : r;
        end
        return r;
    endfunction

    // Arbitration choice among latched requests.
    always_comb begin
        if (ARB_MODE == 1) begin
            sel_s = pick_rr(pending_q, last_q);
        end else begin
            sel_s = pick_fixed(pending_q);
        end
    end

    // Watchdog limit and preemption conditions for the playing channel.
    always_comb begin
        rise_s   = btn & ~btn_prev_q;
        wd_hit_s = (MAX_PLAY_CYCLES > 0) && (int'(wd_q) == MAX_PLAY_CYCLES - 1);
`ifdef MELODY_PREEMPT_EN
        if (ARB_MODE == 1) begin
            preempt_s = (pending_q != '0);
        end else begin
            preempt_s = ((pending_q & (en_q - ONE)) != '0);
        end
`else
        preempt_s = 1'b0;
`endif
    end

    // Main state machine: grant, play, gap.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        act_d      = act_q;
        last_d     = last_q;
        wd_d       = wd_q;
        gap_d      = gap_q;
        timeout_d  = 1'b0;
        grant_oh_s = '0;
        block_s    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    grant_oh_s = ONE << sel_s;
                    block_s    = grant_oh_s;
                    state_d    = ST_PLAY;
                    en_d       = grant_oh_s;
                    act_d      = sel_s;
                    last_d     = sel_s;
                    wd_d       = '0;
                end else begin
                    en_d  = '0;
                    act_d = '0;
                end
            end
            ST_PLAY: begin
                block_s = en_q;
                // done wins a tie with the watchdog limit, so no timeout then
                if (done[act_q] || wd_hit_s) begin
                    state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    en_d      = '0;
                    act_d     = '0;
                    gap_d     = '0;
                    timeout_d = ~done[act_q];
                end else if (preempt_s) begin
                    state_d = ST_IDLE;
                    en_d    = '0;
                    act_d   = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_GAP: begin
                en_d  = '0;
                act_d = '0;
                if (int'(gap_q) >= GAP_CYCLES - 1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
                act_d   = '0;
            end
        endcase
    end

    // Request latching and registered output values.
    always_comb begin
        pending_d = (pending_q | (rise_s & ~block_s)) & ~grant_oh_s;
        busy_d    = (state_d != ST_IDLE);
        if (state_d == ST_PLAY) begin
            buzz_d = melody[act_d];
        end else begin
            buzz_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            en_q       <= '0;
            act_q      <= '0;
            last_q     <= CH_W'(NUM_CH - 1);
            wd_q       <= '0;
            gap_q      <= '0;
            pending_q  <= '0;
            btn_prev_q <= '0;
            buzz_q     <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            act_q      <= act_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            btn_prev_q <= btn;
            buzz_q     <= buzz_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign en        = en_q;
    assign buzz      = buzz_q;
    assign busy      = busy_q;
    assign active_ch = act_q;
    assign pending   = pending_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_melody_arbiter.sv
// Self-checking bench for melody_arbiter: a cycle model per instance plus directed literal checks.
// Instance a: fixed priority, gap 10, watchdog 50. Instance b: round-robin, no gap, no watchdog.
module tb_melody_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_a = 4'b0, done_a = 4'b0, mel_a = 4'b0;
    logic [3:0] btn_b = 4'b0, done_b = 4'b0, mel_b = 4'b0;
    logic [3:0] en_a, pending_a, en_b, pending_b;
    logic       buzz_a, busy_a, timeout_a, buzz_b, busy_b, timeout_b;
    logic [1:0] act_a, act_b;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    melody_arbiter #(.NUM_CH(4), .ARB_MODE(0), .GAP_CYCLES(10), .MAX_PLAY_CYCLES(50)) dut_a (
        .clk(clk), .rst(rst), .btn(btn_a), .done(done_a), .melody(mel_a),
        .en(en_a), .buzz(buzz_a), .busy(busy_a), .active_ch(act_a),
        .pending(pending_a), .timeout(timeout_a));

    melody_arbiter #(.NUM_CH(4), .ARB_MODE(1), .GAP_CYCLES(0), .MAX_PLAY_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .btn(btn_b), .done(done_b), .melody(mel_b),
        .en(en_b), .buzz(buzz_b), .busy(busy_b), .active_ch(act_b),
        .pending(pending_b), .timeout(timeout_b));

    // phase: 0 idle, 1 playing, 2 silent gap
    typedef struct {
        int         phase;
        int         ch;
        int         last;
        int         len;
        int         gap_left;
        logic [3:0] pend;
        logic [3:0] bprev;
        logic       buzz;
        logic       tmo;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = 0; m.ch = 0; m.last = 3; m.len = 0; m.gap_left = 0;
        m.pend = 4'b0; m.bprev = 4'b0; m.buzz = 1'b0; m.tmo = 1'b0;
        return m;
    endfunction

    function automatic int pick(logic [3:0] req, int arb, int last);
        if (arb == 0) begin
            for (int i = 0; i < 4; i++) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
        end
        return 0;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int arb, int gap, int maxp,
                                      logic [3:0] btn, logic [3:0] dn, logic [3:0] mel);
        mdl_t       n;
        logic [3:0] rise;
        logic [3:0] blocked;
        bit         finished;
        n = m; rise = btn & ~m.bprev; blocked = 4'b0; finished = 1'b0;
        n.bprev = btn;
        n.tmo   = 1'b0;
        if (m.phase == 0) begin
            if (m.pend != 4'b0) begin
                n.ch = pick(m.pend, arb, m.last);
                n.last = n.ch; n.len = 0; n.phase = 1;
                n.pend[n.ch] = 1'b0;
                blocked[n.ch] = 1'b1;
            end
        end else if (m.phase == 1) begin
            blocked[m.ch] = 1'b1;
            n.len = m.len + 1;
            if (dn[m.ch]) finished = 1'b1;
            else if (maxp > 0 && n.len == maxp) begin
                finished = 1'b1;
                n.tmo = 1'b1;
            end
`ifdef MELODY_PREEMPT_EN
            else if (arb == 0 ? ((m.pend & ((4'b0001 << m.ch) - 4'b0001)) != 4'b0) : (m.pend != 4'b0))
                n.phase = 0;
`endif
            if (finished) begin
                n.phase = (gap > 0) ? 2 : 0;
                n.gap_left = gap;
            end
        end else begin
            n.gap_left = m.gap_left - 1;
            if (n.gap_left == 0) n.phase = 0;
        end
        n.pend = n.pend | (rise & ~blocked);
        n.buzz = (n.phase == 1) ? mel[n.ch] : 1'b0;
        return n;
    endfunction

    function automatic logic [3:0] m_en(mdl_t m);
        return (m.phase == 1) ? (4'b0001 << m.ch) : 4'b0;
    endfunction

    function automatic logic [1:0] m_act(mdl_t m);
        return (m.phase == 1) ? 2'(m.ch) : 2'b0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= mdl_step(ma, 0, 10, 50, btn_a, done_a, mel_a);
            mb <= mdl_step(mb, 1, 0, 0, btn_b, done_b, mel_b);
        end
    end

    always @(negedge clk) begin
        if ($time > 1) begin
            check("a.en", en_a, m_en(ma));
            check("a.act", act_a, m_act(ma));
            check("a.busy", busy_a, ma.phase != 0);
            check("a.pend", pending_a, ma.pend);
            check("a.buzz", buzz_a, ma.buzz);
            check("a.tmo", timeout_a, ma.tmo);
            check("b.en", en_b, m_en(mb));
            check("b.act", act_b, m_act(mb));
            check("b.busy", busy_b, mb.phase != 0);
            check("b.pend", pending_b, mb.pend);
            check("b.buzz", buzz_b, mb.buzz);
            check("b.tmo", timeout_b, mb.tmo);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_en_a();
        int n = 0;
        while (en_a == 4'b0 && n < 100) begin cyc(); n++; end
        check("a.grant_seen", en_a != 4'b0, 1'b1);
    endtask

    task automatic wait_en_b(output int ch);
        int n = 0;
        while (en_b == 4'b0 && n < 100) begin cyc(); n++; end
        check("b.grant_seen", en_b != 4'b0, 1'b1);
        ch = int'(act_b);
    endtask

    // Pulse done on instance a's active channel and count en-low cycles until the next grant.
    task automatic finish_a(input logic [3:0] d, output int zeros);
        done_a = d;
        cyc();
        done_a = 4'b0;
        zeros = 0;
        while (en_a == 4'b0 && zeros < 200) begin zeros++; cyc(); end
    endtask

    initial begin
        int         ch, zeros, plays;
        logic       tmo_seen;
        int         rr_exp [8] = '{0, 1, 2, 3, 2, 3, 0, 1};
        #1 rst = 1'b1;
        cyc(); cyc();
        check("rst_en", en_a, 4'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_pend", pending_b, 4'b0);
        rst = 1'b0;
        cyc(); cyc();
        check("idle_busy", busy_a, 1'b0);

        // Round-robin order on instance b.
`ifndef MELODY_PREEMPT_EN
        btn_b = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_en_b(ch);
            check($sformatf("rr_first_%0d", i), ch, rr_exp[i]);
            done_b = en_b; cyc(); done_b = 4'b0;
        end
        btn_b = 4'b0; cyc();
        btn_b = 4'b0010;
        wait_en_b(ch);
        check("rr_single", ch, 1);
        done_b = en_b; cyc(); done_b = 4'b0;
        btn_b = 4'b0; cyc();
        btn_b = 4'b1111;
        for (int i = 4; i < 8; i++) begin
            wait_en_b(ch);
            check($sformatf("rr_second_%0d", i - 4), ch, rr_exp[i]);
            done_b = en_b; cyc(); done_b = 4'b0;
        end
        btn_b = 4'b0; cyc(); cyc();
`endif

        // Rise on ch 2: pending next cycle, enable the cycle after, buzz follows melody.
        btn_a[2] = 1'b1;
        cyc();
        check("pend_t1", pending_a, 4'b0100);
        check("en_t1", en_a, 4'b0);
        cyc();
        check("en_t2", en_a, 4'b0100);
        check("act_t2", act_a, 2'd2);
        mel_a = 4'b0100; cyc();
        check("buzz_hi", buzz_a, 1'b1);
        mel_a = 4'b1011; cyc();
        check("buzz_lo", buzz_a, 1'b0);

`ifdef MELODY_PREEMPT_EN
        btn_a[0] = 1'b1;
        cyc();
        check("pre_still", en_a, 4'b0100);
        cyc();
        check("pre_gap", en_a, 4'b0);
        cyc();
        check("pre_new", en_a, 4'b0001);
        check("pre_pend2", pending_a[2], 1'b0);
        done_a = 4'b0001; cyc(); done_a = 4'b0;
        repeat (12) cyc();
`else
        btn_a[3] = 1'b1; btn_a[1] = 1'b1;
        cyc();
        check("pend_31", pending_a, 4'b1010);
        done_a = 4'b1011; cyc();
        check("done_other", en_a, 4'b0100);
        finish_a(4'b0100, zeros);
        check("gap_len1", zeros, 11);
        check("next_ch1", en_a, 4'b0010);
        finish_a(4'b0010, zeros);
        check("gap_len2", zeros, 11);
        check("next_ch3", en_a, 4'b1000);
        done_a = 4'b1000; cyc(); done_a = 4'b0;
        repeat (12) cyc();
        check("back_idle", busy_a, 1'b0);
`endif

        // Watchdog: no done -> 50 play cycles, then timeout with en low, gap entered.
        btn_a = 4'b0; cyc();
        btn_a = 4'b1000;
        wait_en_a();
        plays = 0;
        while (en_a != 4'b0 && plays < 200) begin plays++; cyc(); end
        check("wd_plays", plays, 50);
        check("wd_pulse", timeout_a, 1'b1);
        check("wd_gap", busy_a, 1'b1);
        cyc();
        check("wd_one", timeout_a, 1'b0);
        repeat (12) cyc();

        // done in the same cycle as the watchdog limit: normal completion.
        btn_a[0] = 1'b1;
        wait_en_a();
        tmo_seen = 1'b0;
        repeat (49) begin cyc(); tmo_seen = tmo_seen | timeout_a; end
        done_a = 4'b0001; cyc(); done_a = 4'b0;
        tmo_seen = tmo_seen | timeout_a;
        check("tie_en", en_a, 4'b0);
        check("tie_no_tmo", tmo_seen, 1'b0);
        repeat (12) cyc();

        // Async reset mid-play with pending 1010; btn_b held through release.
        btn_a = 4'b0; cyc();
        btn_a = 4'b0001;
        wait_en_a();
        btn_a = 4'b1011;
        mel_a = 4'b0001;
        cyc(); cyc();
        check("pre_rst_pend", pending_a, 4'b1010);
        check("pre_rst_buzz", buzz_a, 1'b1);
        btn_b = 4'b0100;
        #2 rst = 1'b1;
        #1;
        check("arst_en", en_a, 4'b0);
        check("arst_buzz", buzz_a, 1'b0);
        check("arst_busy", busy_a, 1'b0);
        check("arst_pend", pending_a, 4'b0);
        btn_a = 4'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        check("held_pend", pending_b, 4'b0100);
        cyc();
        check("held_grant", en_b, 4'b0100);
        cyc();
        check("no_grant_en", en_a, 4'b0);
        check("no_grant_busy", busy_a, 1'b0);
        done_b = 4'b0100; cyc(); done_b = 4'b0;
        cyc();
        check("b_done_idle", busy_b, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
